l1_bus_agent: RTL and testbench

- Per-core L1 cache agent; one instance per core, on the core side of the two-core MSI snooping bus controller.
- Initiator role: turns CPU load/store misses and shared-line writes into BusRd/BusUpgr/BusRdX requests, arbitrates with `req_core`/`grant_core`, and fills from the returned data.
- Responder role: snoops the peer core's operations, supplies hit data, performs M/S/I downgrades, and issues flushes to L2.
- Holds a direct-mapped, one-word-per-line tag/state/data array.

---
 rtl/l1_bus_agent.sv | 177 +++++++++++++++++
 tb/tb_l1_bus_agent.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l1_bus_agent.sv
// Per-core L1 agent: direct-mapped MSI cache with bus initiator and snoop responder roles.
// Latency: hits complete in 0 cycles; misses take REQ+DONE (+1 for WB, +1 per blocked WB cycle, +grant wait).
// Backpressure: stall holds the CPU request from the miss cycle through REQ; snoops are never stalled.
// Ports: cpu_* CPU side; req_core/grant_core/bus_*_out/bus_data_in/cache_hit_in/dmem_* initiator side;
//        bus_operation_in/bus_address_in/bus_data_out/cache_hit_out snoop side; flush_out/tag_to_L2/data_to_L2 L2 writeback.
module l1_bus_agent #(
  parameter int INDEX_BITS = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        stall,
  output logic        req_core,
  input  logic        grant_core,
  output logic [1:0]  bus_operation_out,
  output logic [31:0] bus_address_out,
  input  logic [31:0] bus_data_in,
  input  logic [1:0]  cache_hit_in,
  output logic [31:0] dmem_addr,
  input  logic [31:0] dmem_rdata,
  input  logic [1:0]  bus_operation_in,
  input  logic [31:0] bus_address_in,
  output logic [31:0] bus_data_out,
  output logic        cache_hit_out,
  output logic        flush_out,
  output logic [23:0] tag_to_L2,
  output logic [31:0] data_to_L2
);
  localparam int LINES = 1 << INDEX_BITS;
  localparam int TW    = 30 - INDEX_BITS;

  localparam logic [1:0] OP_RD   = 2'b00;
  localparam logic [1:0] OP_UPGR = 2'b01;
  localparam logic [1:0] OP_RDX  = 2'b10;
  localparam logic [1:0] OP_NON  = 2'b11;

  typedef enum logic [1:0] {ST_I, ST_S, ST_M} line_st_e;
  typedef enum logic [1:0] {IDLE, WB, REQ, DONE} fsm_e;

  line_st_e        st_q   [LINES];
  logic [TW-1:0]   tag_q  [LINES];
  logic [31:0]     data_q [LINES];

  fsm_e            fsm_q;
  logic [1:0]      op_q;
  logic [31:0]     addr_q;

  logic [INDEX_BITS-1:0] cpu_idx, req_idx, snp_idx, flush_idx;
  logic [TW-1:0]         cpu_tag, req_tag, snp_tag;
  logic                  cpu_hit, cpu_ok, store_hit_m;
  logic                  snp_hit, snp_inv, snp_flush, wb_flush;
  logic                  done_xfer;
  logic [31:0]           fill_data, line_wdata;
  logic                  unused_addr_bits;

  assign cpu_idx = cpu_addr[INDEX_BITS+1:2];
  assign cpu_tag = cpu_addr[31:INDEX_BITS+2];
  assign req_idx = addr_q[INDEX_BITS+1:2];
  assign req_tag = addr_q[31:INDEX_BITS+2];
  assign snp_idx = bus_address_in[INDEX_BITS+1:2];
  assign snp_tag = bus_address_in[31:INDEX_BITS+2];
  assign unused_addr_bits = ^bus_address_in[1:0];

  // CPU side: an access completes in IDLE when it is a load hit or a store hit on M.
  assign cpu_hit     = (st_q[cpu_idx] != ST_I) && (tag_q[cpu_idx] == cpu_tag);
  assign store_hit_m = cpu_hit && cpu_we && (st_q[cpu_idx] == ST_M);
  assign cpu_ok      = cpu_hit && (!cpu_we || (st_q[cpu_idx] == ST_M));

  // Snoop side.
  assign snp_hit   = (bus_operation_in != OP_NON) && (st_q[snp_idx] != ST_I) &&
                     (tag_q[snp_idx] == snp_tag);
  assign snp_inv   = snp_hit && ((bus_operation_in == OP_RDX) || (bus_operation_in == OP_UPGR));
  assign snp_flush = snp_hit && (st_q[snp_idx] == ST_M);
  // A snoop flush owns the L2 port; a pending writeback waits a cycle.
  assign wb_flush  = (fsm_q == WB) && (st_q[req_idx] == ST_M) && !snp_flush;

  assign cache_hit_out = snp_hit;
  assign bus_data_out  = snp_hit ? data_q[snp_idx] : 32'h0;

  assign flush_out  = snp_flush || wb_flush;
  assign flush_idx  = snp_flush ? snp_idx : req_idx;
  assign tag_to_L2  = flush_out ? 24'(tag_q[flush_idx]) : 24'h0;
  assign data_to_L2 = flush_out ? data_q[flush_idx] : 32'h0;

  // Initiator side.
  assign req_core          = (fsm_q == REQ) && !reset;
  assign bus_operation_out = (fsm_q == REQ) ? op_q : OP_NON;
  assign bus_address_out   = (fsm_q == REQ) ? addr_q : 32'h0;
  assign dmem_addr         = (fsm_q == REQ) ? addr_q : 32'h0;
  assign done_xfer         = req_core && grant_core;
  assign fill_data         = (cache_hit_in == 2'b11) ? dmem_rdata : bus_data_in;
  assign line_wdata        = (op_q == OP_RD) ? fill_data : cpu_wdata;

  always_comb begin
    stall     = 1'b0;
    cpu_rdata = 32'h0;
    case (fsm_q)
      IDLE: begin
        stall = cpu_req && !cpu_ok;
        if (cpu_req && cpu_hit && !cpu_we) cpu_rdata = data_q[cpu_idx];
      end
      WB, REQ: stall = 1'b1;
      DONE:    cpu_rdata = data_q[req_idx];
      default: stall = 1'b0;
    endcase
  end

  // Line state and controller FSM. Later assignments in this block take priority,
  // so the snoop update is written first and the writeback/fill overrides it.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LINES; i++) st_q[i] <= ST_I;
      fsm_q  <= IDLE;
      op_q   <= OP_NON;
      addr_q <= 32'h0;
    end else begin
      if (snp_hit) begin
        if (bus_operation_in == OP_RD) begin
          if (st_q[snp_idx] == ST_M) st_q[snp_idx] <= ST_S;
        end else begin
          st_q[snp_idx] <= ST_I;
        end
      end

      case (fsm_q)
        IDLE: begin
          if (cpu_req && !cpu_ok) begin
            addr_q <= cpu_addr;
            if (cpu_hit) begin
              // Store on S: if the peer invalidates this very line now, the upgrade is stale.
              op_q  <= (snp_inv && (snp_idx == cpu_idx)) ? OP_RDX : OP_UPGR;
              fsm_q <= REQ;
            end else begin
              op_q  <= cpu_we ? OP_RDX : OP_RD;
              fsm_q <= (st_q[cpu_idx] == ST_M) ? WB : REQ;
            end
          end
        end
        WB: begin
          if (!snp_flush) begin
            st_q[req_idx] <= ST_I;
            fsm_q         <= REQ;
          end
        end
        REQ: begin
          if (done_xfer) begin
            st_q[req_idx] <= (op_q == OP_RD) ? ST_S : ST_M;
            fsm_q         <= DONE;
          end else if ((op_q == OP_UPGR) && snp_inv && (snp_idx == req_idx)) begin
            op_q <= OP_RDX;
          end
        end
        DONE: begin
          op_q  <= OP_NON;
          fsm_q <= IDLE;
        end
        default: fsm_q <= IDLE;
      endcase
    end
  end

  // Tag/data array: contents are only meaningful while the line state is valid.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if ((fsm_q == IDLE) && cpu_req && store_hit_m) data_q[cpu_idx] <= cpu_wdata;
      if (done_xfer) begin
        data_q[req_idx] <= line_wdata;
        tag_q[req_idx]  <= req_tag;
      end
    end
  end

endmodule

// File: tb/tb_l1_bus_agent.sv
// Self-checking bench for l1_bus_agent: directed CPU/snoop scenarios with a read-data scoreboard and a flush scoreboard.
// Latency: inputs driven 1 time unit after the rising edge, outputs sampled 1 unit later.
// Backpressure: grant is withheld for a chosen number of REQ cycles per transaction.
module tb_l1_bus_agent;
  logic        clk;
  logic        reset;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        stall, req_core, grant_core;
  logic [1:0]  bus_operation_out;
  logic [31:0] bus_address_out, bus_data_in;
  logic [1:0]  cache_hit_in;
  logic [31:0] dmem_addr, dmem_rdata;
  logic [1:0]  bus_operation_in;
  logic [31:0] bus_address_in, bus_data_out;
  logic        cache_hit_out, flush_out;
  logic [23:0] tag_to_L2;
  logic [31:0] data_to_L2;

  l1_bus_agent #(.INDEX_BITS(6)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .stall(stall),
    .req_core(req_core), .grant_core(grant_core),
    .bus_operation_out(bus_operation_out), .bus_address_out(bus_address_out),
    .bus_data_in(bus_data_in), .cache_hit_in(cache_hit_in),
    .dmem_addr(dmem_addr), .dmem_rdata(dmem_rdata),
    .bus_operation_in(bus_operation_in), .bus_address_in(bus_address_in),
    .bus_data_out(bus_data_out), .cache_hit_out(cache_hit_out),
    .flush_out(flush_out), .tag_to_L2(tag_to_L2), .data_to_L2(data_to_L2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [23:0] tag;
    logic [31:0] data;
  } flush_t;

  logic [31:0] sb_q[$];
  flush_t      fl_q[$];
  int          n_vec  = 0;
  int          n_miss = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Tag of a word address with 6 index bits: addr[31:8].
  function automatic logic [23:0] tag_of(input logic [31:0] a);
    logic [31:0] t;
    t = a >> 8;
    return t[23:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_drive(input logic we, input logic [31:0] addr, input logic [31:0] wd);
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wd;
  endtask

  task automatic cpu_idle();
    cpu_req = 1'b0;
    cpu_we  = 1'b0;
  endtask

  task automatic sb_check(input string tag);
    logic [31:0] e;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'h1, 32'h0);
    end else begin
      e = sb_q.pop_front();
      chk(tag, cpu_rdata, e);
    end
  endtask

  task automatic snoop(input logic [1:0] op, input logic [31:0] addr);
    bus_operation_in = op;
    bus_address_in   = addr;
  endtask

  // Runs a transaction after its miss cycle until stall drops; grant is given
  // once the request has been seen for more than gwait cycles.
  task automatic finish_miss(input int gwait, output int cycles, output int rq,
                             output logic [1:0] op, output logic [31:0] addr,
                             output logic [31:0] daddr);
    bit done;
    cycles = 0; rq = 0; op = 2'b11; addr = 32'h0; daddr = 32'h0; done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      tick();
      cycles++;
      if (req_core) begin
        rq++;
        if (rq == 1) begin
          op    = bus_operation_out;
          addr  = bus_address_out;
          daddr = dmem_addr;
        end
        grant_core = (rq > gwait);
      end else begin
        grant_core = 1'b0;
      end
      #1;
      if (!stall) done = 1;
    end
    if (!done) chk("miss_timeout", 32'h1, 32'h0);
  endtask

  task automatic load_hit(input logic [31:0] addr, input logic [31:0] exp, input string tag);
    tick();
    cpu_drive(1'b0, addr, 32'h0);
    sb_q.push_back(exp);
    #1;
    chk({tag, "_stall"}, 32'(stall), 32'h0);
    sb_check({tag, "_rdata"});
    cpu_idle();
  endtask

  // Flush monitor: every L2 write must match the next expected flush.
  always @(negedge clk) begin : flush_mon
    flush_t e;
    if (!reset && flush_out) begin
      if (fl_q.size() == 0) begin
        chk("flush_unexpected", 32'h1, 32'h0);
      end else begin
        e = fl_q.pop_front();
        chk("flush_tag", 32'(tag_to_L2), 32'(e.tag));
        chk("flush_data", data_to_L2, e.data);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: run did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          cyc, rq;
    logic [1:0]  op;
    logic [31:0] a, da;

    reset = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    grant_core = 0; bus_data_in = 0; cache_hit_in = 2'b11; dmem_rdata = 0;
    bus_operation_in = 2'b11; bus_address_in = 0;
    repeat (2) tick();
    reset = 1'b0;
    #1;
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_req", 32'(req_core), 32'h0);
    chk("rst_op", 32'(bus_operation_out), 32'h3);
    chk("rst_baddr", bus_address_out, 32'h0);
    chk("rst_daddr", dmem_addr, 32'h0);
    chk("rst_snp_hit", 32'(cache_hit_out), 32'h0);
    chk("rst_flush", 32'(flush_out), 32'h0);

    // Cold load, data from memory, granted in the first REQ cycle.
    tick();
    cpu_drive(1'b0, 32'h0000_0100, 32'h0);
    cache_hit_in = 2'b11; dmem_rdata = 32'hDEAD_BEEF; bus_data_in = 32'h0BAD_0001;
    sb_q.push_back(32'hDEAD_BEEF);
    #1;
    chk("cold_miss_stall", 32'(stall), 32'h1);
    chk("cold_no_req_yet", 32'(req_core), 32'h0);
    finish_miss(0, cyc, rq, op, a, da);
    chk("cold_cycles", 32'(cyc), 32'd2);
    chk("cold_req_cycles", 32'(rq), 32'd1);
    chk("cold_op", 32'(op), 32'h0);
    chk("cold_baddr", a, 32'h0000_0100);
    chk("cold_daddr", da, 32'h0000_0100);
    sb_check("cold_rdata");
    tick(); cpu_idle();
    load_hit(32'h0000_0100, 32'hDEAD_BEEF, "cold_rehit");

    // Store to the shared line -> upgrade.
    tick();
    cpu_drive(1'b1, 32'h0000_0100, 32'h11);
    #1;
    chk("upgr_stall", 32'(stall), 32'h1);
    finish_miss(0, cyc, rq, op, a, da);
    chk("upgr_op", 32'(op), 32'h1);
    chk("upgr_cycles", 32'(cyc), 32'd2);
    sb_q.push_back(32'h11);
    sb_check("upgr_done_rdata");
    tick(); cpu_idle();
    load_hit(32'h0000_0100, 32'h11, "upgr_load");

    // Snoop BusRd on the M line: supply data, flush, drop to S.
    tick();
    snoop(2'b00, 32'h0000_0100);
    fl_q.push_back({tag_of(32'h0000_0100), 32'h11});
    #1;
    chk("snp_m_hit", 32'(cache_hit_out), 32'h1);
    chk("snp_m_data", bus_data_out, 32'h11);
    chk("snp_no_stall", 32'(stall), 32'h0);
    tick();
    #1;
    chk("snp_s_hit", 32'(cache_hit_out), 32'h1);
    chk("snp_s_noflush", 32'(flush_out), 32'h0);
    tick(); snoop(2'b11, 32'h0);

    // Make the line M again, then miss on a conflicting tag -> WB then BusRd from L2.
    tick();
    cpu_drive(1'b1, 32'h0000_0100, 32'h22);
    #1;
    finish_miss(0, cyc, rq, op, a, da);
    chk("upgr2_op", 32'(op), 32'h1);
    tick(); cpu_idle();
    tick();
    cpu_drive(1'b0, 32'h0001_0100, 32'h0);
    cache_hit_in = 2'b10; bus_data_in = 32'h0000_CAFE; dmem_rdata = 32'hBAD0_BAD0;
    fl_q.push_back({tag_of(32'h0000_0100), 32'h22});
    sb_q.push_back(32'h0000_CAFE);
    #1;
    chk("wb_miss_stall", 32'(stall), 32'h1);
    finish_miss(0, cyc, rq, op, a, da);
    chk("wb_cycles", 32'(cyc), 32'd3);
    chk("wb_op", 32'(op), 32'h0);
    chk("wb_baddr", a, 32'h0001_0100);
    sb_check("wb_fill_rdata");
    tick(); cpu_idle();
    tick(); snoop(2'b00, 32'h0000_0100);
    #1;
    chk("evicted_snp_hit", 32'(cache_hit_out), 32'h0);
    chk("evicted_snp_data", bus_data_out, 32'h0);
    tick(); snoop(2'b00, 32'h0001_0100);
    #1;
    chk("newline_snp_data", bus_data_out, 32'h0000_CAFE);
    tick(); snoop(2'b11, 32'h0);

    // Pending upgrade, grant withheld 3 cycles, peer BusRdX in the 2nd REQ cycle.
    tick();
    cpu_drive(1'b1, 32'h0001_0100, 32'h55);
    #1;
    chk("pend_stall", 32'(stall), 32'h1);
    tick(); #1;
    chk("pend_req_c1", 32'(req_core), 32'h1);
    chk("pend_op_c1", 32'(bus_operation_out), 32'h1);
    tick(); snoop(2'b10, 32'h0001_0100);
    #1;
    chk("rdx_snp_hit", 32'(cache_hit_out), 32'h1);
    chk("pend_op_c2", 32'(bus_operation_out), 32'h1);
    tick(); snoop(2'b11, 32'h0);
    #1;
    chk("converted_op", 32'(bus_operation_out), 32'h2);
    chk("converted_stall", 32'(stall), 32'h1);
    tick(); grant_core = 1'b1;
    #1;
    chk("granted_op", 32'(bus_operation_out), 32'h2);
    tick(); grant_core = 1'b0;
    #1;
    chk("rdx_done_stall", 32'(stall), 32'h0);
    sb_q.push_back(32'h55);
    sb_check("rdx_done_rdata");
    tick(); cpu_idle();
    tick();
    cpu_drive(1'b1, 32'h0001_0100, 32'h66);
    #1;
    chk("store_hit_m_stall", 32'(stall), 32'h0);
    tick(); cpu_idle();
    load_hit(32'h0001_0100, 32'h66, "store_hit_m_load");
    tick(); snoop(2'b00, 32'h0001_0100);
    fl_q.push_back({tag_of(32'h0001_0100), 32'h66});
    #1;
    chk("m_after_rdx_snp_data", bus_data_out, 32'h66);
    tick(); snoop(2'b11, 32'h0);

    // Reset while requesting.
    tick();
    cpu_drive(1'b0, 32'h0000_0200, 32'h0);
    #1;
    chk("prereset_stall", 32'(stall), 32'h1);
    tick(); #1;
    chk("prereset_req", 32'(req_core), 32'h1);
    reset = 1'b1;
    #1;
    chk("req_drop_in_reset", 32'(req_core), 32'h0);
    tick(); reset = 1'b0; cpu_idle();
    #1;
    chk("postreset_req", 32'(req_core), 32'h0);
    chk("postreset_op", 32'(bus_operation_out), 32'h3);
    chk("postreset_stall", 32'(stall), 32'h0);
    tick(); snoop(2'b00, 32'h0001_0100);
    #1;
    chk("postreset_snp_hit", 32'(cache_hit_out), 32'h0);
    tick(); snoop(2'b11, 32'h0);
    cpu_drive(1'b0, 32'h0001_0100, 32'h0);
    cache_hit_in = 2'b11; dmem_rdata = 32'h0000_7777; bus_data_in = 32'h0BAD_0002;
    sb_q.push_back(32'h0000_7777);
    #1;
    chk("postreset_miss", 32'(stall), 32'h1);
    finish_miss(2, cyc, rq, op, a, da);
    chk("late_grant_req_cycles", 32'(rq), 32'd3);
    chk("late_grant_cycles", 32'(cyc), 32'd4);
    sb_check("late_grant_rdata");
    tick(); cpu_idle();

    repeat (2) tick();
    chk("flush_queue_drained", 32'(fl_q.size()), 32'h0);
    chk("sb_drained", 32'(sb_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
